sipo: RTL and testbench

Serial-in, parallel-out deserialiser; the receive-side counterpart of the parallel-to-serial shifter. It collects a gated serial bit stream, LSB first by default, into `WIDTH`-bit words. Each completed word is presented on a one-entry valid/ready output register. Sits directly downstream of the serialiser, or of the link it drives, and feeds word-oriented logic.

---
 rtl/sipo_pkg.sv | 8 +
 rtl/sipo.sv | 86 ++++++++
 tb/tb_sipo.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/sipo_pkg.sv
// Shared constants for the serialiser/deserialiser pair.
// Both ends use these same bit-order encodings.
package sipo_pkg;

  localparam bit BitOrderLsb = 1'b0;
  localparam bit BitOrderMsb = 1'b1;

endpackage

// File: rtl/sipo.sv
// Serial-in, parallel-out deserialiser.
// Assembles gated serial bits into Width-bit words behind a one-entry valid/ready register.
module sipo
  import sipo_pkg::*;
#(
  parameter int unsigned Width    = 8,
  parameter bit          MsbFirst = BitOrderLsb
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             sync_i,
  input  logic             ser_i,
  input  logic             ser_valid_i,
  output logic [Width-1:0] dout_o,
  output logic             dout_valid_o,
  input  logic             dout_ready_i,
  output logic             overrun_o
);

  localparam int unsigned CntW = $clog2(Width);
  localparam logic [CntW-1:0] CntLast = CntW'(Width - 1);

  logic [Width-1:0] sh_q, sh_d, sh_shifted;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [Width-1:0] dout_q, dout_d;
  logic             dout_valid_q, dout_valid_d;
  logic             overrun_q, overrun_d;
  logic             complete, consume;

  assign sh_shifted = (MsbFirst == BitOrderMsb) ? {sh_q[Width-2:0], ser_i}
                                                : {ser_i, sh_q[Width-1:1]};

  // sync suppresses completion: a realigned stream never emits the partial word.
  assign complete = ser_valid_i && (cnt_q == CntLast) && !sync_i;
  assign consume  = dout_valid_q && dout_ready_i;

  always_comb begin
    sh_d  = sh_q;
    cnt_d = cnt_q;
    if (ser_valid_i) begin
      sh_d  = sh_shifted;
      cnt_d = (cnt_q == CntLast) ? '0 : cnt_q + CntW'(1);
    end
    if (sync_i) begin
      cnt_d = ser_valid_i ? CntW'(1) : '0;
    end
  end

  always_comb begin
    dout_d       = dout_q;
    dout_valid_d = dout_valid_q;
    overrun_d    = overrun_q;
    if (complete && (!dout_valid_q || consume)) begin
      dout_d       = sh_shifted;
      dout_valid_d = 1'b1;
    end else if (complete) begin
      overrun_d = 1'b1;
    end else if (consume) begin
      dout_valid_d = 1'b0;
    end
    if (sync_i) begin
      overrun_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sh_q         <= '0;
      cnt_q        <= '0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      sh_q         <= sh_d;
      cnt_q        <= cnt_d;
      dout_q       <= dout_d;
      dout_valid_q <= dout_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign dout_o       = dout_q;
  assign dout_valid_o = dout_valid_q;
  assign overrun_o    = overrun_q;

endmodule

// File: tb/tb_sipo.sv
// Scoreboard bench for sipo: one LSB-first and one MSB-first instance share the stimulus.
// Expected words are queued at issue time and checked by a monitor on every transfer.
module tb_sipo;
  import sipo_pkg::*;

  logic       clk = 1'b0;
  logic       rst_n, sync, ser, ser_valid, dout_ready;
  logic [7:0] dout_l, dout_m;
  logic       valid_l, valid_m, ovr_l, ovr_m;

  int errors = 0;
  int checks = 0;
  logic [7:0] q_l[$];
  logic [7:0] q_m[$];

  always #5 clk = ~clk;

  sipo #(.Width(8), .MsbFirst(BitOrderLsb)) u_lsb (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(sync), .ser_i(ser), .ser_valid_i(ser_valid),
    .dout_o(dout_l), .dout_valid_o(valid_l), .dout_ready_i(dout_ready), .overrun_o(ovr_l)
  );

  sipo #(.Width(8), .MsbFirst(BitOrderMsb)) u_msb (
    .clk_i(clk), .rst_ni(rst_n), .sync_i(sync), .ser_i(ser), .ser_valid_i(ser_valid),
    .dout_o(dout_m), .dout_valid_o(valid_m), .dout_ready_i(dout_ready), .overrun_o(ovr_m)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] bitrev(input logic [7:0] w);
    for (int i = 0; i < 8; i++) bitrev[i] = w[7-i];
  endfunction

  // Monitor: every transfer (valid && ready) must match the head of its queue.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
      if (valid_l && dout_ready) begin
        if (q_l.size() == 0) check("lsb_unexpected_word", {24'd0, dout_l}, 32'hFFFF_FFFF);
        else check("lsb_word", {24'd0, dout_l}, {24'd0, q_l.pop_front()});
      end
      if (valid_m && dout_ready) begin
        if (q_m.size() == 0) check("msb_unexpected_word", {24'd0, dout_m}, 32'hFFFF_FFFF);
        else check("msb_word", {24'd0, dout_m}, {24'd0, q_m.pop_front()});
      end
    end
  end

  // Presents one bit for exactly one edge; entered and left at posedge+1.
  task automatic bit_in(input logic b);
    ser       = b;
    ser_valid = 1'b1;
    @(posedge clk); #1;
    ser_valid = 1'b0;
  endtask

  // First transmitted bit is w[0]; the MSB-first instance therefore sees bitrev(w).
  task automatic send_word(input logic [7:0] w, input bit push, input int gap);
    if (push) begin
      q_l.push_back(w);
      q_m.push_back(bitrev(w));
    end
    for (int i = 0; i < 8; i++) begin
      bit_in(w[i]);
      repeat (gap) begin @(posedge clk); #1; end
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  initial begin
    rst_n = 1'b0; sync = 1'b0; ser = 1'b0; ser_valid = 1'b0; dout_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_valid_l", {31'd0, valid_l}, 0);
    check("reset_dout_l", {24'd0, dout_l}, 0);
    check("reset_ovr_l", {31'd0, ovr_l}, 0);
    check("reset_valid_m", {31'd0, valid_m}, 0);
    rst_n = 1'b1;
    idle(2);

    // Bits 1,0,1,0,0,1,0,1 -> A5 in both orders; valid one cycle after, gone one after that.
    dout_ready = 1'b1;
    send_word(8'hA5, 1, 0);
    check("a5_valid_rise", {31'd0, valid_l}, 1);
    check("a5_dout_direct", {24'd0, dout_l}, 32'hA5);
    idle(1);
    check("a5_valid_drop", {31'd0, valid_l}, 0);
    check("a5_dout_held", {24'd0, dout_l}, 32'hA5);
    idle(2);

    // Bits 0,...,0,1: LSB-first gives 80, MSB-first gives 01; gapped input.
    send_word(8'h80, 1, 2);
    check("p01_msb_direct", {24'd0, dout_m}, 32'h01);
    idle(3);

    // Overrun: two words with no consumer.
    dout_ready = 1'b0;
    send_word(8'h3C, 1, 0);
    check("ovr_after_w1", {31'd0, ovr_l}, 0);
    send_word(8'hC3, 0, 0);
    check("ovr_set", {31'd0, ovr_l}, 1);
    check("ovr_set_m", {31'd0, ovr_m}, 1);
    check("ovr_dout_kept", {24'd0, dout_l}, 32'h3C);
    sync = 1'b1;
    idle(1);
    sync = 1'b0;
    check("sync_clears_ovr", {31'd0, ovr_l}, 0);
    check("sync_keeps_valid", {31'd0, valid_l}, 1);
    dout_ready = 1'b1;
    idle(1);
    check("ovr_consumed", {31'd0, valid_l}, 0);
    idle(2);

    // Completion coincident with consume: new word replaces old with no gap.
    dout_ready = 1'b0;
    send_word(8'h5A, 1, 0);
    q_l.push_back(8'h96);
    q_m.push_back(bitrev(8'h96));
    for (int i = 0; i < 7; i++) bit_in(ser_bit(8'h96, i));
    dout_ready = 1'b1;
    bit_in(1'b1);
    check("coinc_valid", {31'd0, valid_l}, 1);
    check("coinc_dout", {24'd0, dout_l}, 32'h96);
    check("coinc_no_ovr", {31'd0, ovr_l}, 0);
    idle(2);

    // sync with a bit: first 3 bits discarded, sync bit becomes bit 0.
    q_l.push_back(8'h01);
    q_m.push_back(8'h80);
    repeat (3) bit_in(1'b1);
    sync = 1'b1;
    bit_in(1'b1);
    sync = 1'b0;
    repeat (7) bit_in(1'b0);
    check("sync_word_l", {24'd0, dout_l}, 32'h01);
    idle(2);

    // Async reset mid-word with a word held and overrun set.
    dout_ready = 1'b0;
    send_word(8'hE7, 0, 0);
    send_word(8'h18, 0, 0);
    repeat (3) bit_in(1'b1);
    check("pre_rst_valid", {31'd0, valid_l}, 1);
    #2 rst_n = 1'b0;
    #1;
    check("arst_valid_l", {31'd0, valid_l}, 0);
    check("arst_dout_l", {24'd0, dout_l}, 0);
    check("arst_ovr_l", {31'd0, ovr_l}, 0);
    check("arst_valid_m", {31'd0, valid_m}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    dout_ready = 1'b1;
    send_word(8'h6B, 1, 0);

    // Bounded drain of the scoreboard.
    for (int i = 0; i < 50 && (q_l.size() != 0 || q_m.size() != 0); i++) idle(1);
    idle(2);
    check("lsb_queue_drained", q_l.size(), 0);
    check("msb_queue_drained", q_m.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  function automatic logic ser_bit(input logic [7:0] w, input int i);
    ser_bit = w[i];
  endfunction

endmodule
